// File: rtl/arb_pkg.sv
// Shared types and default constants for the round-robin arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    localparam int ARB_N_DEF        = 4;
    localparam int ARB_MAX_HOLD_DEF = 8;

endpackage

// File: rtl/arb_rr_pick.sv
// Rotate-and-pick: first set request bit at or above ptr, wrapping N-1 -> 0.
module arb_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         request,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         winner,
    output logic [$clog2(N)-1:0] index,
    output logic                 valid
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] pos;

    always_comb begin
        winner = '0;
        index  = '0;
        valid  = 1'b0;
        pos    = '0;
        for (int off = 0; off < N; off++) begin
            pos = PW'((int'(ptr) + off) % N);
            if (!valid && request[pos]) begin
                valid       = 1'b1;
                winner[pos] = 1'b1;
                index       = pos;
            end
        end
    end

endmodule

// File: rtl/arb_rr.sv
// Round-robin arbiter with burst lock and registered one-hot grant.
// Define ARB_TIMEOUT_EN to bound each ownership to MAX_HOLD cycles when others wait.
//
// state     | meaning
// ARB_IDLE  | no owner, grant = 0
// ARB_OWNED | exactly one grant bit set, held while its request stays high
module arb_rr
    import arb_pkg::*;
#(
    parameter int N        = ARB_N_DEF,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         request,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 preempt
);
    localparam int PW = $clog2(N);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [PW-1:0] gnt_id_q, gnt_id_d;
    logic          busy_q, busy_d;
    logic [PW-1:0] ptr_q, ptr_d;

    logic [N-1:0]  pick_winner;
    logic [PW-1:0] pick_index;
    logic          pick_valid;
    logic [PW-1:0] ptr_next;
    logic          take;

`ifdef ARB_TIMEOUT_EN
    logic [7:0]    hold_q, hold_d;
    logic          preempt_q, preempt_d;
`endif

    // The current owner is masked out so a timeout can only hand over to someone else.
    arb_rr_pick #(.N(N)) u_pick (
        .request (request & ~grant_q),
        .ptr     (ptr_q),
        .winner  (pick_winner),
        .index   (pick_index),
        .valid   (pick_valid)
    );

    assign ptr_next = (pick_index == PW'(N - 1)) ? '0 : PW'(pick_index + PW'(1));

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        take     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        preempt_d = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) take = 1'b1;
            end
            ARB_OWNED: begin
                if (!request[gnt_id_q]) begin
                    if (pick_valid) begin
                        take = 1'b1;
                    end else begin
                        state_d  = ARB_IDLE;
                        grant_d  = '0;
                        gnt_id_d = '0;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == 8'(MAX_HOLD - 1)) begin
                    // Saturated: stay put unless someone else is waiting.
                    if (pick_valid) begin
                        take      = 1'b1;
                        preempt_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d  = ARB_IDLE;
                grant_d  = '0;
                gnt_id_d = '0;
            end
        endcase
        if (take) begin
            state_d  = ARB_OWNED;
            grant_d  = pick_winner;
            gnt_id_d = pick_index;
            ptr_d    = ptr_next;
`ifdef ARB_TIMEOUT_EN
            hold_d   = '0;
`endif
        end
        busy_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign preempt = preempt_q;
`else
    assign preempt = 1'b0;
`endif

    assign grant  = grant_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;

endmodule

// File: doc/arb_rr.md
ARB_RR -- requirements
Module: arb_rr

Interface
REQ-001 The block SHALL have parameter N, default 4, number of requesters (range 2..16).
REQ-002 The block SHALL have parameter MAX_HOLD, default 8, maximum grant cycles per owner when the timeout feature is compiled in (range 2..255).
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port request, input, N, one bit per requester; level-sensitive; held high for as long as access is wanted.
REQ-006 The block SHALL have port grant, output, N, registered, one-hot or zero.
REQ-007 The block SHALL have port gnt_id, output, $clog2(N), registered index of the current owner; 0 when grant is zero.
REQ-008 The block SHALL have port busy, output, 1, registered; equals |grant.
REQ-009 The block SHALL have port preempt, output, 1, registered single-cycle pulse marking a timeout-forced handover.

Function
REQ-010 The FSM SHALL have two states: IDLE (grant=0) and OWNED (exactly one grant bit set).
REQ-011 In IDLE, request!=0 sampled at edge k SHALL set grant at edge k (visible the cycle after request), with latency 1, and the FSM SHALL move to OWNED.
REQ-012 Winner selection SHALL be round-robin: the first set request bit searching upward from pointer ptr, wrapping N-1 -> 0.
REQ-013 On every new grant to index i, ptr SHALL update to (i+1) mod N.
REQ-014 In OWNED, grant SHALL be held unchanged while request[gnt_id]=1 (burst lock), regardless of other requests.
REQ-015 In OWNED, request[gnt_id]=0 sampled SHALL hand over at that edge to the round-robin winner among the remaining requests, with no idle cycle; if none remain, grant SHALL go to 0 and the FSM to IDLE.
REQ-016 A one-cycle request pulse SHALL produce a grant for exactly one cycle.
REQ-017 grant SHALL never have more than one bit set; gnt_id and busy SHALL always be consistent with grant.
REQ-018 Requesters that are not granted SHALL be served within N-1 ownership periods (no starvation).

Reset
REQ-019 rst=1 sampled SHALL force grant=0, gnt_id=0, busy=0, preempt=0, ptr=0, hold counter=0, state IDLE at that edge, overriding all other activity including mid-burst ownership.
REQ-020 Requests SHALL be ignored while rst=1; arbitration SHALL resume on the first edge with rst=0.

Configuration
REQ-021 Macro ARB_TIMEOUT_EN defined SHALL add a hold counter that clears on each new grant and increments each owned cycle; when the owner has held for MAX_HOLD cycles and another request is pending, it SHALL hand over at that edge per REQ-012 and pulse preempt for 1 cycle.
REQ-022 With ARB_TIMEOUT_EN defined and no other request pending, the owner SHALL keep the grant and the counter SHALL saturate.
REQ-023 Without ARB_TIMEOUT_EN, there SHALL be no counter, hold time SHALL be unlimited, and preempt SHALL be tied to 0.

Structure
REQ-024 Package arb_pkg SHALL hold the FSM state enum (ARB_IDLE, ARB_OWNED) and the default constants ARB_N_DEF=4 and ARB_MAX_HOLD_DEF=8.
REQ-025 Combinational rotate-and-pick logic SHALL be a sub-module arb_rr_pick (inputs request and ptr; outputs one-hot winner, index and valid), instantiated once.

Verification (N=4, MAX_HOLD=8)
REQ-026 Reset then request=0001 -> grant=0001 the next cycle, gnt_id=0, busy=1; drop request -> grant=0000 the next cycle.
REQ-027 request=1111 held, each owner dropping its bit after 2 cycles -> grant sequence 0001, 0010, 0100, 1000 with no gap cycles.
REQ-028 Owner 1 holding with request=0110 while ptr=2; owner drops -> grant=0100 at the next edge; ptr=3.
REQ-029 With ARB_TIMEOUT_EN, request=0011 held continuously -> 0001 for 8 cycles, preempt pulse, then 0010 for 8 cycles, and so on alternating; without the macro -> 0001 held indefinitely and preempt=0.
REQ-030 rst=1 for 1 cycle during an ownership of 1000 -> grant=0000 the next cycle; with request=1000 still high after rst=0 -> grant=1000 one cycle later, ptr=0.
